// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with one-cycle rx_valid / rx_frame_err strobes.
//            Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int BAUD_DIVISOR = 868,
  parameter int HALF_DIVISOR = BAUD_DIVISOR / 2
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam logic [9:0] c_baud_reload = 10'(BAUD_DIVISOR - 1);
  localparam logic [9:0] c_half_reload = 10'(HALF_DIVISOR - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_rx_meta, r_rx_s, r_rx_prev;
  logic [9:0]  r_timer, w_timer_next;
  logic [2:0]  r_bit_cnt, w_bit_cnt_next;
  logic [7:0]  r_shift, w_shift_next;
  logic [7:0]  w_data_next;
  logic        w_valid_next, w_err_next;
  logic        w_sample_pt, w_bit;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // History holds rx_s from the timer==2 and timer==1 cycles when timer==0.
  logic [1:0] r_hist;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) r_hist <= 2'b11;
    else     r_hist <= {r_hist[0], r_rx_s};
  end

  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
  assign w_bit = r_rx_s;
`endif

  assign w_sample_pt = (r_timer == 10'd0);
  assign rx_busy     = (r_state != S_IDLE);

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= 10'd0;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_shift      <= w_shift_next;
      rx_data      <= w_data_next;
      rx_valid     <= w_valid_next;
      rx_frame_err <= w_err_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = (r_state == S_IDLE) ? r_timer : r_timer - 10'd1;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_data_next    = rx_data;
    w_valid_next   = 1'b0;
    w_err_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_state_next = S_START;
          w_timer_next = c_half_reload;
        end
      end
      S_START: begin
        if (w_sample_pt) begin
          w_timer_next = c_baud_reload;
          if (!w_bit) begin
            w_state_next   = S_DATA;
            w_bit_cnt_next = 3'd0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_sample_pt) begin
          w_timer_next   = c_baud_reload;
          w_shift_next   = {w_bit, r_shift[7:1]};
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_sample_pt) begin
          w_timer_next = c_baud_reload;
          if (w_bit) begin
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_err_next   = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Stay here while the line is held low so a break yields one error only.
        if (r_rx_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
